ctrl_input_conditioner: RTL and testbench

Board-input front end for the 8-bit bidirectional shift register stage. Synchronises and debounces three raw push-button keys and an 8-bit switch bank, then drives the shift stage's `pause`, `dir`, `load` and `parallel_in` inputs with clean levels. It also provides one-cycle press strobes for other consumers. It sits directly upstream of the shift stage, between the board pins and that stage.

---
 rtl/ctrl_input_conditioner.sv | 128 ++++++++++++
 tb/tb_ctrl_input_conditioner.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_input_conditioner.sv
// ctrl_input_conditioner: board-pin front end for the 8-bit shift stage.
// Synchronises and debounces three active-low keys and an 8-bit switch bank,
// then drives clean pause/dir toggles, the load level, the parallel word and
// one-cycle press strobes. Every output comes straight from a flop.

module ctrl_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_raw,
  input  logic [7:0] sw_raw,
  output logic       pause,
  output logic       dir,
  output logic       load,
  output logic [7:0] parallel_out,
  output logic [2:0] press_pulse
);

  localparam int CW_RAW = $clog2(DEBOUNCE_CYCLES);
  localparam int CW = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Synchroniser stages; keys idle high (released), switches idle low.
  logic [2:0]         keyMeta_q, keySync_q;
  logic [7:0]         swMeta_q, swSync_q;

  // Key debounce state.
  logic [2:0]         keyStable_q, keyStable_d;
  logic [2:0][CW-1:0] keyCnt_q, keyCnt_d;
  logic [2:0]         keyPress;

  // Switch-word debounce state.
  logic [7:0]         swPrev_q;
  logic [7:0]         swStable_q, swStable_d;
  logic [CW-1:0]      swCnt_q, swCnt_d;

  // Registered outputs.
  logic               pause_q, pause_d;
  logic               dir_q, dir_d;
  logic [2:0]         pulse_q;

  // Two-flop synchronisers for every raw board input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keyMeta_q <= 3'b111;
      keySync_q <= 3'b111;
      swMeta_q  <= 8'h00;
      swSync_q  <= 8'h00;
    end else begin
      keyMeta_q <= key_raw;
      keySync_q <= keyMeta_q;
      swMeta_q  <= sw_raw;
      swSync_q  <= swMeta_q;
    end
  end

  // Per-key debounce: count cycles the synchronised level disagrees with the
  // stable level and accept it once the disagreement has lasted long enough.
  always_comb begin
    keyStable_d = keyStable_q;
    keyCnt_d    = keyCnt_q;
    keyPress    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (keySync_q[i] == keyStable_q[i]) begin
        keyCnt_d[i] = '0;
      end else if (keyCnt_q[i] == CNT_MAX) begin
        keyStable_d[i] = keySync_q[i];
        keyCnt_d[i]    = '0;
        keyPress[i]    = keyStable_q[i];
      end else begin
        keyCnt_d[i] = keyCnt_q[i] + CNT_ONE;
      end
    end
  end

  // Toggle outputs flip on the same edge a press is accepted.
  always_comb begin
    pause_d = pause_q ^ keyPress[0];
    dir_d   = dir_q ^ keyPress[1];
  end

  // Switch word debounce: the whole word must sit unchanged and differ from
  // the stable word for the full window, so a mid-count change restarts it.
  always_comb begin
    swStable_d = swStable_q;
    swCnt_d    = swCnt_q;
    if ((swSync_q != swPrev_q) || (swSync_q == swStable_q)) begin
      swCnt_d = '0;
    end else if (swCnt_q == CNT_MAX) begin
      swStable_d = swSync_q;
      swCnt_d    = '0;
    end else begin
      swCnt_d = swCnt_q + CNT_ONE;
    end
  end

  // State registers for debounce, toggles and press strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keyStable_q <= 3'b111;
      keyCnt_q    <= '0;
      swPrev_q    <= 8'h00;
      swStable_q  <= 8'h00;
      swCnt_q     <= '0;
      pause_q     <= 1'b0;
      dir_q       <= 1'b0;
      pulse_q     <= 3'b000;
    end else begin
      keyStable_q <= keyStable_d;
      keyCnt_q    <= keyCnt_d;
      swPrev_q    <= swSync_q;
      swStable_q  <= swStable_d;
      swCnt_q     <= swCnt_d;
      pause_q     <= pause_d;
      dir_q       <= dir_d;
      pulse_q     <= keyPress;
    end
  end

  assign pause        = pause_q;
  assign dir          = dir_q;
  assign load         = keyStable_q[2];
  assign parallel_out = swStable_q;
  assign press_pulse  = pulse_q;

endmodule

// File: tb/tb_ctrl_input_conditioner.sv
// Testbench for ctrl_input_conditioner with DEBOUNCE_CYCLES = 4.
// A behavioural model keeps the history of synchronised samples and accepts a
// new level when the most recent window of samples all disagree with it.

module tb_ctrl_input_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] key_raw;
  logic [7:0] sw_raw;
  logic       pause;
  logic       dir;
  logic       load;
  logic [7:0] parallel_out;
  logic [2:0] press_pulse;

  int checks = 0;
  int errors = 0;

  ctrl_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_raw      (key_raw),
    .sw_raw       (sw_raw),
    .pause        (pause),
    .dir          (dir),
    .load         (load),
    .parallel_out (parallel_out),
    .press_pulse  (press_pulse)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [2:0] mS1, mS2;
  logic [7:0] mW1, mW2;
  logic [2:0] kHist[$];
  logic [7:0] wHist[$];
  logic [2:0] mSt;
  logic [7:0] mWs;
  logic       mPause, mDir;
  logic [2:0] mPulse;
  logic       flip, same;

  task automatic modelReset();
    mS1 = 3'b111; mS2 = 3'b111;
    mW1 = 8'h00;  mW2 = 8'h00;
    mSt = 3'b111; mWs = 8'h00;
    mPause = 1'b0; mDir = 1'b0; mPulse = 3'b000;
    kHist.delete();
    repeat (D) kHist.push_back(3'b111);
    wHist.delete();
    repeat (D + 1) wHist.push_back(8'h00);
  endtask

  // Model: a key level is accepted when the last D synchronised samples all
  // differ from the stable level; a word when the last D+1 samples are one
  // identical word different from the stable word.
  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        modelReset();
      end else begin
        kHist.push_back(mS2);
        if (kHist.size() > D) void'(kHist.pop_front());
        mPulse = 3'b000;
        for (int i = 0; i < 3; i++) begin
          flip = 1'b1;
          foreach (kHist[j]) if (kHist[j][i] == mSt[i]) flip = 1'b0;
          if (flip) begin
            if (mSt[i]) mPulse[i] = 1'b1;
            mSt[i] = ~mSt[i];
          end
        end
        if (mPulse[0]) mPause = ~mPause;
        if (mPulse[1]) mDir = ~mDir;
        wHist.push_back(mW2);
        if (wHist.size() > D + 1) void'(wHist.pop_front());
        same = 1'b1;
        foreach (wHist[j]) if (wHist[j] !== wHist[0]) same = 1'b0;
        if (same && (wHist[0] !== mWs)) mWs = wHist[0];
        mS2 = mS1; mS1 = key_raw;
        mW2 = mW1; mW1 = sw_raw;
      end
    end
  end

  function automatic logic [13:0] modelOut();
    return {mPause, mDir, mSt[2], mWs, mPulse};
  endfunction

  task automatic test_reset();
    int ffCycle;
    reset = 1'b0; key_raw = 3'b111; sw_raw = 8'hFF;
    repeat (3) @(negedge clk);
    checks++;
    if ({pause, dir, load, parallel_out, press_pulse} !== {1'b0, 1'b0, 1'b1, 8'h00, 3'b000}) begin
      errors++;
      $display("[TB] FAIL reset_values actual %h expected %h",
               {pause, dir, load, parallel_out, press_pulse}, {1'b0, 1'b0, 1'b1, 8'h00, 3'b000});
    end
    reset = 1'b1;
    ffCycle = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ffCycle < 0 && parallel_out == 8'hFF) ffCycle = c;
      checks++;
      if ({pause, dir, load, parallel_out, press_pulse} !== modelOut()) begin
        errors++;
        $display("[TB] FAIL reset_release cyc %0d actual %h expected %h", c,
                 {pause, dir, load, parallel_out, press_pulse}, modelOut());
      end
    end
    checks++;
    if (ffCycle !== 7) begin
      errors++;
      $display("[TB] FAIL reset_sw_latency actual %0d expected 7", ffCycle);
    end
  endtask

  task automatic test_clean_press();
    int pauseCycle, pulseCycle, pulseCount;
    for (int phase = 0; phase < 4; phase++) begin
      key_raw[0] = phase[0];
      pauseCycle = -1; pulseCycle = -1; pulseCount = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (pauseCycle < 0 && pause == (phase == 0)) pauseCycle = c;
        if (press_pulse[0]) begin
          pulseCount++;
          if (pulseCycle < 0) pulseCycle = c;
        end
        checks++;
        if ({pause, dir, load, parallel_out, press_pulse} !== modelOut()) begin
          errors++;
          $display("[TB] FAIL clean_press ph %0d cyc %0d actual %h expected %h", phase, c,
                   {pause, dir, load, parallel_out, press_pulse}, modelOut());
        end
      end
      if (phase == 0) begin
        checks++;
        if (pauseCycle !== 6 || pulseCycle !== 6 || pulseCount !== 1) begin
          errors++;
          $display("[TB] FAIL press_latency actual toggle %0d pulse %0d count %0d expected 6 6 1",
                   pauseCycle, pulseCycle, pulseCount);
        end
      end else begin
        checks++;
        if (pulseCount !== (phase == 2 ? 1 : 0)) begin
          errors++;
          $display("[TB] FAIL press_pulse_count ph %0d actual %0d expected %0d",
                   phase, pulseCount, (phase == 2 ? 1 : 0));
        end
      end
    end
    checks++;
    if (pause !== 1'b0) begin
      errors++;
      $display("[TB] FAIL second_press_toggle actual %b expected 0", pause);
    end
  endtask

  task automatic test_bounce();
    int pulseCount;
    logic pattern [9];
    pattern = '{0, 0, 0, 1, 1, 0, 0, 0, 1};
    pulseCount = 0;
    for (int c = 0; c < 24; c++) begin
      key_raw[1] = (c < 9) ? pattern[c] : 1'b1;
      @(negedge clk);
      if (press_pulse != 3'b000) pulseCount++;
      checks++;
      if ({pause, dir, load, parallel_out, press_pulse} !== modelOut()) begin
        errors++;
        $display("[TB] FAIL bounce cyc %0d actual %h expected %h", c,
                 {pause, dir, load, parallel_out, press_pulse}, modelOut());
      end
    end
    checks++;
    if (dir !== 1'b0 || pulseCount !== 0) begin
      errors++;
      $display("[TB] FAIL bounce_reject actual dir %b pulses %0d expected 0 0", dir, pulseCount);
    end
  endtask

  task automatic test_load_simul();
    int loadCycle, pulseCount, bothCycle;
    for (int phase = 0; phase < 2; phase++) begin
      key_raw[2] = phase[0];
      loadCycle = -1; pulseCount = 0;
      for (int c = 1; c <= 14; c++) begin
        @(negedge clk);
        if (loadCycle < 0 && load == phase[0]) loadCycle = c;
        if (press_pulse[2]) pulseCount++;
        checks++;
        if ({pause, dir, load, parallel_out, press_pulse} !== modelOut()) begin
          errors++;
          $display("[TB] FAIL load ph %0d cyc %0d actual %h expected %h", phase, c,
                   {pause, dir, load, parallel_out, press_pulse}, modelOut());
        end
      end
      checks++;
      if (loadCycle !== 6 || pulseCount !== (phase == 0 ? 1 : 0)) begin
        errors++;
        $display("[TB] FAIL load_latency ph %0d actual %0d pulses %0d expected 6 %0d",
                 phase, loadCycle, pulseCount, (phase == 0 ? 1 : 0));
      end
    end
    key_raw[1:0] = 2'b00;
    bothCycle = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bothCycle < 0 && press_pulse == 3'b011) bothCycle = c;
      checks++;
      if ({pause, dir, load, parallel_out, press_pulse} !== modelOut()) begin
        errors++;
        $display("[TB] FAIL simul cyc %0d actual %h expected %h", c,
                 {pause, dir, load, parallel_out, press_pulse}, modelOut());
      end
    end
    checks++;
    if (bothCycle !== 6 || pause !== 1'b1 || dir !== 1'b1) begin
      errors++;
      $display("[TB] FAIL simul_press actual cyc %0d pause %b dir %b expected 6 1 1",
               bothCycle, pause, dir);
    end
    key_raw[1:0] = 2'b11;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_switch();
    int hitCycle;
    logic saw3C;
    sw_raw = 8'h00;
    repeat (10) @(negedge clk);
    sw_raw = 8'hA5;
    hitCycle = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (hitCycle < 0 && parallel_out == 8'hA5) hitCycle = c;
      checks++;
      if ({pause, dir, load, parallel_out, press_pulse} !== modelOut()) begin
        errors++;
        $display("[TB] FAIL switch cyc %0d actual %h expected %h", c,
                 {pause, dir, load, parallel_out, press_pulse}, modelOut());
      end
    end
    checks++;
    if (hitCycle !== 7) begin
      errors++;
      $display("[TB] FAIL switch_latency actual %0d expected 7", hitCycle);
    end
    sw_raw = 8'h3C;
    repeat (2) @(negedge clk);
    sw_raw = 8'h5A;
    hitCycle = -1; saw3C = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (hitCycle < 0 && parallel_out == 8'h5A) hitCycle = c;
      if (parallel_out == 8'h3C) saw3C = 1'b1;
      checks++;
      if ({pause, dir, load, parallel_out, press_pulse} !== modelOut()) begin
        errors++;
        $display("[TB] FAIL switch_restart cyc %0d actual %h expected %h", c,
                 {pause, dir, load, parallel_out, press_pulse}, modelOut());
      end
    end
    checks++;
    if (hitCycle !== 7 || saw3C) begin
      errors++;
      $display("[TB] FAIL switch_midcount actual cyc %0d saw3C %b expected 7 0", hitCycle, saw3C);
    end
  endtask

  task automatic test_reset_mid();
    int pulseCycle;
    key_raw[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({pause, dir, load, parallel_out, press_pulse} !== {1'b0, 1'b0, 1'b1, 8'h00, 3'b000}) begin
      errors++;
      $display("[TB] FAIL reset_mid_values actual %h expected %h",
               {pause, dir, load, parallel_out, press_pulse}, {1'b0, 1'b0, 1'b1, 8'h00, 3'b000});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulseCycle = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (pulseCycle < 0 && press_pulse[0]) pulseCycle = c;
      checks++;
      if ({pause, dir, load, parallel_out, press_pulse} !== modelOut()) begin
        errors++;
        $display("[TB] FAIL reset_mid cyc %0d actual %h expected %h", c,
                 {pause, dir, load, parallel_out, press_pulse}, modelOut());
      end
    end
    checks++;
    if (pulseCycle !== 6 || pause !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_press actual cyc %0d pause %b expected 6 1", pulseCycle, pause);
    end
    key_raw[0] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(5) == 0) key_raw[$urandom_range(2)] ^= 1'b1;
      if ($urandom_range(7) == 0) sw_raw = 8'($urandom);
      @(negedge clk);
      checks++;
      if ({pause, dir, load, parallel_out, press_pulse} !== modelOut()) begin
        errors++;
        $display("[TB] FAIL random cyc %0d actual %h expected %h", c,
                 {pause, dir, load, parallel_out, press_pulse}, modelOut());
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    key_raw = 3'b111;
    sw_raw = 8'hFF;
    test_reset();
    test_clean_press();
    test_bounce();
    test_load_simul();
    test_switch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
